// File: rtl/mem_stage_access.sv
// Memory-stage access controller: dmem req/ack handshake, upstream stall, branch/jal redirect, MEM/WB register.
// Optional access timeout is built when MEM_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no access pending; non-memory ops flow straight to MEM/WB
// ACCESS | request held on dmem until ack (or timeout)
// DONE   | access finished; MEM/WB loads the instruction, EX/MEM advances
module mem_stage_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EXMEM_Branch,
  input  logic        EXMEM_MemRead,
  input  logic        EXMEM_MemWrite,
  input  logic        EXMEM_MemtoReg,
  input  logic        EXMEM_RegWrite,
  input  logic        EXMEM_Jal,
  input  logic        EXMEM_Zero,
  input  logic [4:0]  EXMEM_RD,
  input  logic [63:0] EXMEM_Adder2Out,
  input  logic [63:0] EXMEM_Result,
  input  logic [63:0] EXMEM_WriteData,
  input  logic [63:0] EXMEM_adder_out1,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        mem_stall,
  output logic        PCSrc,
  output logic [63:0] Branch_Target,
  output logic        MEMWB_RegWrite,
  output logic        MEMWB_MemtoReg,
  output logic        MEMWB_Jal,
  output logic [4:0]  MEMWB_RD,
  output logic [63:0] MEMWB_ReadData,
  output logic [63:0] MEMWB_Result,
  output logic [63:0] MEMWB_adder_out1,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        memop;
  logic        abort;
  logic        timed_out;
  logic        wb_load;
  logic [63:0] wb_rdata_nxt;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic        we_q;

  assign memop         = EXMEM_MemRead | EXMEM_MemWrite;
  assign dmem_req      = (state == ACCESS);
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign mem_stall     = (state == ACCESS) | ((state == IDLE) & memop);
  assign PCSrc         = (EXMEM_Branch & EXMEM_Zero) | EXMEM_Jal;
  assign Branch_Target = EXMEM_Adder2Out;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] to_cnt;
  logic          to_hit;
  logic          to_done_q;
  logic          to_err_q;

  // an ack arriving on the limit cycle takes priority over the abort
  assign to_hit      = (state == ACCESS) && !dmem_ack && (to_cnt == CW'(TIMEOUT - 1));
  assign abort       = to_hit;
  assign timed_out   = to_done_q;
  assign timeout_err = to_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt    <= '0;
      to_done_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      if (state == IDLE && memop)
        to_cnt <= '0;
      else if (state == ACCESS && !dmem_ack)
        to_cnt <= to_cnt + 1'b1;
      if (state == ACCESS)
        to_done_q <= to_hit;
      if (to_hit)
        to_err_q <= 1'b1;
    end
  end
`else
  assign abort       = 1'b0;
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (memop) state_nxt = ACCESS;
      ACCESS:  if (dmem_ack || abort) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_load      = ((state == IDLE) && !memop) || ((state == DONE) && !timed_out);
    wb_rdata_nxt = (state == DONE) ? rdata_q : 64'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && memop) begin
        addr_q  <= EXMEM_Result;
        wdata_q <= EXMEM_WriteData;
        we_q    <= EXMEM_MemWrite;
      end
      // stores report zero read data
      if (state == ACCESS && dmem_ack)
        rdata_q <= we_q ? 64'd0 : dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEMWB_RegWrite   <= 1'b0;
      MEMWB_MemtoReg   <= 1'b0;
      MEMWB_Jal        <= 1'b0;
      MEMWB_RD         <= '0;
      MEMWB_ReadData   <= '0;
      MEMWB_Result     <= '0;
      MEMWB_adder_out1 <= '0;
    end else if (wb_load) begin
      MEMWB_RegWrite   <= EXMEM_RegWrite;
      MEMWB_MemtoReg   <= EXMEM_MemtoReg;
      MEMWB_Jal        <= EXMEM_Jal;
      MEMWB_RD         <= EXMEM_RD;
      MEMWB_ReadData   <= wb_rdata_nxt;
      MEMWB_Result     <= EXMEM_Result;
      MEMWB_adder_out1 <= EXMEM_adder_out1;
    end else begin
      MEMWB_RegWrite   <= 1'b0;
      MEMWB_MemtoReg   <= 1'b0;
      MEMWB_Jal        <= 1'b0;
      MEMWB_RD         <= '0;
      MEMWB_ReadData   <= '0;
      MEMWB_Result     <= '0;
      MEMWB_adder_out1 <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: vector table for non-memory ops plus load/store/reset/timeout sequences.
module tb_mem_stage_access;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        jal;
    logic [4:0]  rd;
    logic [63:0] readdata;
    logic [63:0] result;
    logic [63:0] adder1;
  } wb_t;

  typedef struct {
    logic        branch, zero, jal, regwrite, memtoreg;
    logic [4:0]  rd;
    logic [63:0] adder2, result, adder1;
    logic        exp_pcsrc;
    wb_t         exp_wb;
  } vec_t;

  localparam wb_t ZERO_WB = '0;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXMEM_Branch, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg;
  logic        EXMEM_RegWrite, EXMEM_Jal, EXMEM_Zero;
  logic [4:0]  EXMEM_RD;
  logic [63:0] EXMEM_Adder2Out, EXMEM_Result, EXMEM_WriteData, EXMEM_adder_out1;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, PCSrc;
  logic [63:0] Branch_Target;
  logic        MEMWB_RegWrite, MEMWB_MemtoReg, MEMWB_Jal;
  logic [4:0]  MEMWB_RD;
  logic [63:0] MEMWB_ReadData, MEMWB_Result, MEMWB_adder_out1;
  logic        timeout_err;

  int   checks = 0;
  int   failures = 0;
  wb_t  exp_q[$];
  vec_t vecs[5];

  mem_stage_access dut (
    .clk(clk), .reset(reset),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .EXMEM_MemtoReg(EXMEM_MemtoReg), .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_Jal(EXMEM_Jal),
    .EXMEM_Zero(EXMEM_Zero), .EXMEM_RD(EXMEM_RD), .EXMEM_Adder2Out(EXMEM_Adder2Out),
    .EXMEM_Result(EXMEM_Result), .EXMEM_WriteData(EXMEM_WriteData), .EXMEM_adder_out1(EXMEM_adder_out1),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .PCSrc(PCSrc),
    .Branch_Target(Branch_Target), .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_MemtoReg(MEMWB_MemtoReg),
    .MEMWB_Jal(MEMWB_Jal), .MEMWB_RD(MEMWB_RD), .MEMWB_ReadData(MEMWB_ReadData),
    .MEMWB_Result(MEMWB_Result), .MEMWB_adder_out1(MEMWB_adder_out1), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic wb_t cur_wb();
    wb_t w;
    w.regwrite = MEMWB_RegWrite;
    w.memtoreg = MEMWB_MemtoReg;
    w.jal      = MEMWB_Jal;
    w.rd       = MEMWB_RD;
    w.readdata = MEMWB_ReadData;
    w.result   = MEMWB_Result;
    w.adder1   = MEMWB_adder_out1;
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // push the expected MEM/WB content, clock once, pop and compare
  task automatic step(input string name, input wb_t e);
    wb_t x;
    wb_t a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    a = cur_wb();
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s memwb: got %h expected %h", name, a, x);
    end
  endtask

  task automatic set_nop();
    EXMEM_Branch = 0; EXMEM_MemRead = 0; EXMEM_MemWrite = 0; EXMEM_MemtoReg = 0;
    EXMEM_RegWrite = 0; EXMEM_Jal = 0; EXMEM_Zero = 0; EXMEM_RD = 0;
    EXMEM_Adder2Out = 0; EXMEM_Result = 0; EXMEM_WriteData = 0; EXMEM_adder_out1 = 0;
  endtask

  task automatic set_memop(input logic we, input logic [4:0] rd, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] adder1);
    set_nop();
    EXMEM_MemRead    = !we;
    EXMEM_MemWrite   = we;
    EXMEM_MemtoReg   = !we;
    EXMEM_RegWrite   = !we;
    EXMEM_RD         = we ? 5'd0 : rd;
    EXMEM_Result     = addr;
    EXMEM_WriteData  = wdata;
    EXMEM_adder_out1 = adder1;
  endtask

  // one memory instruction with ack on ACCESS cycle k
  task automatic mem_op(input string name, input logic we, input logic [4:0] rd,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic [63:0] adder1, input int k);
    int  stalls;
    int  reqs;
    wb_t e;
    stalls = 0;
    reqs = 0;
    set_memop(we, rd, addr, wdata, adder1);
    #1;
    if (mem_stall) stalls++;
    chk({name, " req_idle"}, 64'(dmem_req), 64'd0);
    step({name, " detect"}, ZERO_WB);
    for (int i = 1; i <= k; i++) begin
      if (mem_stall) stalls++;
      if (dmem_req) reqs++;
      chk({name, " addr"}, dmem_addr, addr);
      chk({name, " we"}, 64'(dmem_we), 64'(we));
      if (we) chk({name, " wdata"}, dmem_wdata, wdata);
      if (i == k) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      step({name, " access"}, ZERO_WB);
      dmem_ack = 1'b0;
      dmem_rdata = 64'hFFFF_0000_FFFF_0000;
    end
    chk({name, " stall_done"}, 64'(mem_stall), 64'd0);
    chk({name, " req_done"}, 64'(dmem_req), 64'd0);
    e.regwrite = !we;
    e.memtoreg = !we;
    e.jal      = 1'b0;
    e.rd       = we ? 5'd0 : rd;
    e.readdata = we ? 64'd0 : rdata;
    e.result   = addr;
    e.adder1   = adder1;
    step({name, " done"}, e);
    set_nop();
    chk({name, " stall_cycles"}, 64'(stalls), 64'(k + 1));
    chk({name, " req_cycles"}, 64'(reqs), 64'(k));
    #1;
    chk({name, " no_reissue"}, 64'(dmem_req), 64'd0);
    step({name, " idle"}, ZERO_WB);
    chk({name, " no_reissue2"}, 64'(dmem_req), 64'd0);
  endtask

  initial begin
    int reqs;
    //        br zr jal rw m2r rd  adder2      result      adder1     pcsrc  {rw,m2r,jal,rd,readdata,result,adder1}
    vecs[0] = '{0, 0, 0, 1, 0, 5'd5,  64'h0,   64'h2A,  64'h1004, 1'b0, '{1'b1, 1'b0, 1'b0, 5'd5,  64'h0, 64'h2A,  64'h1004}};
    vecs[1] = '{1, 1, 0, 0, 0, 5'd0,  64'h400, 64'h0,   64'h1008, 1'b1, '{1'b0, 1'b0, 1'b0, 5'd0,  64'h0, 64'h0,   64'h1008}};
    vecs[2] = '{1, 0, 0, 0, 0, 5'd0,  64'h500, 64'h7,   64'h100C, 1'b0, '{1'b0, 1'b0, 1'b0, 5'd0,  64'h0, 64'h7,   64'h100C}};
    vecs[3] = '{0, 0, 1, 1, 0, 5'd1,  64'h800, 64'h0,   64'h2004, 1'b1, '{1'b1, 1'b0, 1'b1, 5'd1,  64'h0, 64'h0,   64'h2004}};
    vecs[4] = '{0, 1, 0, 1, 1, 5'd31, 64'h900, 64'h123, 64'h3000, 1'b0, '{1'b1, 1'b1, 1'b0, 5'd31, 64'h0, 64'h123, 64'h3000}};

    reset = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 64'd0;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", 64'(dmem_req), 64'd0);
    chk("rst stall", 64'(mem_stall), 64'd0);
    chk("rst timeout_err", 64'(timeout_err), 64'd0);
    checks++;
    if (cur_wb() !== ZERO_WB) begin
      failures++;
      $display("FAIL rst memwb: got %h expected %h", cur_wb(), ZERO_WB);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      EXMEM_Branch = vecs[i].branch;
      EXMEM_Zero = vecs[i].zero;
      EXMEM_Jal = vecs[i].jal;
      EXMEM_RegWrite = vecs[i].regwrite;
      EXMEM_MemtoReg = vecs[i].memtoreg;
      EXMEM_RD = vecs[i].rd;
      EXMEM_Adder2Out = vecs[i].adder2;
      EXMEM_Result = vecs[i].result;
      EXMEM_adder_out1 = vecs[i].adder1;
      EXMEM_WriteData = 64'hABCD;
      #1;
      chk($sformatf("vec%0d pcsrc", i), 64'(PCSrc), 64'(vecs[i].exp_pcsrc));
      chk($sformatf("vec%0d target", i), Branch_Target, vecs[i].adder2);
      chk($sformatf("vec%0d stall", i), 64'(mem_stall), 64'd0);
      chk($sformatf("vec%0d req", i), 64'(dmem_req), 64'd0);
      step($sformatf("vec%0d", i), vecs[i].exp_wb);
    end
    set_nop();

    mem_op("load", 1'b0, 5'd7, 64'h100, 64'h0, 64'hDEAD, 64'h4000, 3);
    mem_op("store", 1'b1, 5'd0, 64'h80, 64'h55, 64'h9999, 64'h4004, 1);
    mem_op("load_k1", 1'b0, 5'd9, 64'h188, 64'h0, 64'hCAFE_F00D, 64'h4008, 1);

    dmem_ack = 1'b1;
    dmem_rdata = 64'hBAD;
    #1;
    chk("stray_ack req", 64'(dmem_req), 64'd0);
    step("stray_ack", ZERO_WB);
    dmem_ack = 1'b0;
    chk("stray_ack stall", 64'(mem_stall), 64'd0);

    set_memop(1'b0, 5'd3, 64'h200, 64'h0, 64'h5000);
    step("rst_mid detect", ZERO_WB);
    chk("rst_mid req_before", 64'(dmem_req), 64'd1);
    chk("rst_mid addr_before", dmem_addr, 64'h200);
    reset = 1'b0;
    #1;
    chk("rst_mid req", 64'(dmem_req), 64'd0);
    chk("rst_mid addr", dmem_addr, 64'd0);
    chk("rst_mid memwb_rw", 64'(MEMWB_RegWrite), 64'd0);
    set_nop();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid stall_after", 64'(mem_stall), 64'd0);
    chk("rst_mid req_after", 64'(dmem_req), 64'd0);

`ifdef MEM_TIMEOUT_EN
    reqs = 0;
    set_memop(1'b0, 5'd4, 64'h300, 64'h0, 64'h6000);
    step("to detect", ZERO_WB);
    for (int i = 1; i <= 16; i++) begin
      if (dmem_req) reqs++;
      step("to access", ZERO_WB);
    end
    chk("to req_dropped", 64'(dmem_req), 64'd0);
    chk("to stall_done", 64'(mem_stall), 64'd0);
    step("to done_bubble", ZERO_WB);
    chk("to req_cycles", 64'(reqs), 64'd16);
    chk("to err_set", 64'(timeout_err), 64'd1);
    set_nop();
    step("to idle1", ZERO_WB);
    step("to idle2", ZERO_WB);
    chk("to err_sticky", 64'(timeout_err), 64'd1);
`else
    reqs = 0;
    chk("no_timeout err", 64'(timeout_err), 64'(reqs));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_access.md
# mem_stage_access

Memory-stage access controller of the pipelined core, consuming the EX/MEM register outputs. It runs a req/ack handshake with a variable-latency data memory for loads and stores, and stalls the upstream pipeline while an access is outstanding. It resolves branch and jal redirection and loads the MEM/WB pipeline register, including bubbles during stalls.

## Interface
- `TIMEOUT`, 16: ACCESS cycles without ack before abort; used only when `MEM_TIMEOUT_EN` is defined.
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state.
- `EXMEM_Branch`, `EXMEM_MemRead`, `EXMEM_MemWrite`, `EXMEM_MemtoReg`, `EXMEM_RegWrite`, `EXMEM_Jal`, `EXMEM_Zero`  in  1 each  EX/MEM control and Zero.
- `EXMEM_RD`  in  5  destination register.
- `EXMEM_Adder2Out`  in  64  branch target.
- `EXMEM_Result`  in  64  ALU result / memory address.
- `EXMEM_WriteData`  in  64  store data.
- `EXMEM_adder_out1`  in  64  PC+4 for jal link.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  64  access address.
- `dmem_wdata`  out  64  store data.
- `dmem_ack`  in  1  one-cycle completion pulse.
- `dmem_rdata`  in  64  load data, valid with ack.
- `mem_stall`  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- `PCSrc`  out  1  redirect fetch.
- `Branch_Target`  out  64  redirect address.
- `MEMWB_RegWrite`, `MEMWB_MemtoReg`, `MEMWB_Jal`  out  1 each  registered WB controls.
- `MEMWB_RD`  out  5  registered destination.
- `MEMWB_ReadData`, `MEMWB_Result`, `MEMWB_adder_out1`  out  64 each  registered WB data.
- `timeout_err`  out  1  sticky abort flag.

## Operation
- memop = `EXMEM_MemRead` | `EXMEM_MemWrite`. If both are set, the access is a store.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no memop: MEM/WB loads the EX/MEM fields with `MEMWB_ReadData`=0. `mem_stall`=0.
- IDLE, memop: latch addr=`EXMEM_Result`, wdata=`EXMEM_WriteData`, we=`EXMEM_MemWrite` into holding registers. Go to ACCESS. `mem_stall`=1. MEM/WB loads a bubble.
- ACCESS: `dmem_req`=1, with addr/we/wdata driven from the holding registers and stable until ack. `mem_stall`=1. MEM/WB loads a bubble.
- ACCESS, on `dmem_ack`: capture `dmem_rdata` and go to DONE.
- DONE: `mem_stall`=0. MEM/WB loads the instruction with the captured read data (0 for stores). Next state is IDLE, and EX/MEM advances at the same edge.
- Bubble: `MEMWB_RegWrite`=`MEMWB_MemtoReg`=`MEMWB_Jal`=0 and `MEMWB_RD`=0. Data fields are don't-care and implemented as 0.
- `dmem_ack` outside ACCESS is ignored.
- `PCSrc` = (`EXMEM_Branch` & `EXMEM_Zero`) | `EXMEM_Jal`, combinational. `Branch_Target` = `EXMEM_Adder2Out`.
- Reset (0): state IDLE, all registered outputs 0, `dmem_req` drops immediately, `timeout_err`=0. A pending access is abandoned mid-operation.

## Timing
- Non-memory instruction: MEM/WB is valid 1 cycle after the EX/MEM edge, with no stall.
- Memory access with ack in ACCESS cycle k (k ≥ 1): `mem_stall` is high for k+1 cycles (IDLE-detect cycle plus k ACCESS cycles). MEM/WB holds the instruction 1 cycle after DONE.
- Minimum memory op cost: 2 stall cycles.
- `mem_stall` is combinational from state and memop, so it is valid in the same cycle an op arrives.
- `dmem_req` is combinational from state only.

## Configuration
- `MEM_TIMEOUT_EN` defined: a counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - On reaching `TIMEOUT`: `dmem_req` drops, go to DONE, and MEM/WB gets a bubble (no register write).
  - `timeout_err` is set and stays set until reset.
  - An ack in the same cycle as the limit wins, and the access completes normally.
- `MEM_TIMEOUT_EN` undefined: ACCESS waits indefinitely. `timeout_err` is tied 0 and no counter is built.

## Test plan
- Reset low mid-ACCESS -> `dmem_req`=0 immediately. All MEM/WB outputs 0. After release, state IDLE with `mem_stall`=0.
- R-type, `EXMEM_RegWrite`=1, RD=5, Result=0x2A -> next edge gives `MEMWB_RegWrite`=1, `MEMWB_RD`=5, `MEMWB_Result`=0x2A, no stall.
- Load, Result=0x100, ack on 3rd ACCESS cycle with rdata=0xDEAD -> `mem_stall` high 4 cycles. `dmem_addr`=0x100 held throughout. MEM/WB then carries ReadData=0xDEAD with bubbles during the stall.
- Store, Result=0x80, WriteData=0x55, ack on 1st ACCESS cycle -> `dmem_we`=1 and `dmem_wdata`=0x55. 2 stall cycles. Exactly one request is issued (no re-issue after DONE).
- Branch=1, Zero=1, Adder2Out=0x400 -> `PCSrc`=1 and `Branch_Target`=0x400 in the same cycle. With Zero=0 and Jal=0 -> `PCSrc`=0.
- `MEM_TIMEOUT_EN`, `TIMEOUT`=16, no ack -> req drops after 16 ACCESS cycles. `timeout_err`=1 and stays set. MEM/WB RegWrite=0.
